core_inst_issuer: RTL

- Instruction front-end for the HDC `core`; drives the core's `run`, `get_v`, `get_d` and `exec` inputs.
- Accepts 16-bit core instructions from an upstream valid/ready stream and buffers them in a small FIFO.
- Issues one instruction per cycle with the get_v→exec one-cycle offset the core requires.
- Terminates a program on the lastore instruction and closes it once the core's `last` pulse arrives.

---
 rtl/core_inst_issuer_if.sv | 10 +
 rtl/core_inst_issuer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/core_inst_issuer_if.sv
// Upstream instruction stream for core_inst_issuer: 16-bit core words with a
// valid/ready handshake.
interface core_inst_issuer_if;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/core_inst_issuer.sv
// Instruction front-end for the HDC core: buffers upstream words, issues one per
// cycle as get_v/get_d with exec one cycle behind, and stops after lastore.
module core_inst_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  core_inst_issuer_if.slave    s_if,
  output logic                 run,
  output logic                 get_v,
  output logic [15:0]          get_d,
  output logic                 exec,
  input  logic                 core_last,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     inst_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_WAIT_LAST = 2'd2;
  localparam logic [1:0] ST_CLEAR     = 2'd3;

  logic [15:0]      mem_r [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r;
  logic [1:0]       state_r, state_next_s;
  logic             stop_r, stop_next_s;
  logic             s_ready_r, ready_next_s;
  logic             run_r, get_v_r, exec_r, busy_r, done_r;
  logic [15:0]      get_d_r;
  logic [CNT_W-1:0] inst_count_r;

  logic             push_s, pop_s, flush_s, abort_s, done_s, cnt_clr_s, is_last_s;
  logic [AW:0]      fill_s, fill_next_s;
  logic [15:0]      pop_word_s;

  assign s_if.s_ready = s_ready_r;
  assign run          = run_r;
  assign get_v        = get_v_r;
  assign get_d        = get_d_r;
  assign exec         = exec_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign inst_count   = inst_count_r;

  // Next-state, FIFO handshake and stop-flag decisions.
  always_comb begin
    state_next_s = state_r;
    stop_next_s  = stop_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    flush_s      = 1'b0;
    done_s       = 1'b0;
    cnt_clr_s    = 1'b0;
    abort_s      = abort && (state_r != ST_IDLE);
    fill_s       = wr_ptr_r - rd_ptr_r;
    pop_word_s   = mem_r[rd_ptr_r[AW-1:0]];
    // lastore: bit15=0, bits[14:11]=0, bit10=1
    is_last_s    = (pop_word_s[15:10] == 6'b000001);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          flush_s      = 1'b1;
          cnt_clr_s    = 1'b1;
          stop_next_s  = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_next_s = ST_CLEAR;
          flush_s      = 1'b1;
        end else begin
          push_s = s_if.s_valid && s_ready_r;
          pop_s  = !stop_r && (fill_s != {(AW+1){1'b0}});
          if (pop_s && is_last_s) begin
            stop_next_s = 1'b1;
          end else begin
            stop_next_s = stop_r;
          end
          // The lastore exec cycle is the only one with stop set, exec high and get_v low.
          if (stop_r && exec_r && !get_v_r) begin
            state_next_s = ST_WAIT_LAST;
          end else begin
            state_next_s = ST_RUN;
          end
        end
      end
      ST_WAIT_LAST: begin
        if (abort_s) begin
          state_next_s = ST_CLEAR;
          flush_s      = 1'b1;
        end else if (core_last) begin
          state_next_s = ST_CLEAR;
          done_s       = 1'b1;
        end else begin
          state_next_s = ST_WAIT_LAST;
        end
      end
      ST_CLEAR: begin
        if (abort_s) begin
          state_next_s = ST_CLEAR;
          flush_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        flush_s      = 1'b1;
      end
    endcase

    if (flush_s) begin
      fill_next_s = {(AW+1){1'b0}};
    end else begin
      fill_next_s = fill_s + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end
    ready_next_s = (state_next_s == ST_RUN) && !stop_next_s &&
                   (fill_next_s != (AW+1)'(FIFO_DEPTH));
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= s_if.s_data;
    end
  end

  // Control state, FIFO pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      stop_r       <= 1'b0;
      wr_ptr_r     <= {(AW+1){1'b0}};
      rd_ptr_r     <= {(AW+1){1'b0}};
      s_ready_r    <= 1'b0;
      run_r        <= 1'b0;
      get_v_r      <= 1'b0;
      get_d_r      <= 16'h0000;
      exec_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      inst_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      stop_r    <= stop_next_s;
      s_ready_r <= ready_next_s;
      if (flush_s) begin
        wr_ptr_r <= {(AW+1){1'b0}};
        rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
        if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      run_r   <= (state_next_s == ST_RUN) || (state_next_s == ST_WAIT_LAST);
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= done_s;
      get_v_r <= pop_s;
      get_d_r <= pop_s ? pop_word_s : 16'h0000;
      exec_r  <= abort_s ? 1'b0 : get_v_r;
      if (cnt_clr_s) begin
        inst_count_r <= {CNT_W{1'b0}};
      end else if (pop_s) begin
        inst_count_r <= inst_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
